// File: rtl/lsu_dm_port.sv
// lsu_dm_port
// -----------
// Load/store unit between the rv32i memory stage and the word-wide data
// memory DM. It accepts one byte-addressed RV32I load or store at a time.
// DM only writes whole words, so sb/sh run as a read-modify-write sequence.
// Load data is sign- or zero-extended and returned with a one-cycle strobe.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned
// halfword/word accesses with rsp_err. When it is not defined, the offending
// low address bits are ignored.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req_valid/ready request handshake; ready only while idle
//   req_we          1 = store, 0 = load
//   req_funct3      RV32I funct3 (lb/lh/lw/lbu/lhu, sb/sh/sw)
//   req_addr        byte address; bits above ADDR_W+1 are ignored (wrap)
//   req_wdata       right-aligned store data
//   rsp_valid       one-cycle completion strobe
//   rsp_rdata       extended load data (0 for stores and errors)
//   rsp_err         request rejected, no memory access performed
//   dm_we/addr/wd   DM write enable, word address, write word
//   dm_rd           DM read word, combinational from dm_addr
module lsu_dm_port #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wd,
    input  logic [31:0]       dm_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         buf_q;
    logic                err_q;
    logic                req_err;
    logic                accept;

    // Address bits above the DM range are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    // Illegal funct3 codes: loads 011/110/111, stores 011 and 1xx.
    function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
        logic ill;
        if (we) ill = (f3 == 3'b011) || f3[2];
        else    ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        return ill;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            2'b01:   mis = lo[0];
            2'b10:   mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction
`endif

    // Select the addressed lane of the buffered word and extend it.
    // Halfword lane uses lo[1] only, word ignores lo entirely.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lo);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = 32'(b);           // lb: sign extend
            3'b001:  r = 32'(h);           // lh: sign extend
            3'b100:  r = {24'h000000, b};  // lbu
            3'b101:  r = {16'h0000, h};    // lhu
            default: r = word;             // lw
        endcase
        return r;
    endfunction

    // Replace the addressed lane of the buffered word with store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wd,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lo);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00:   r[{lo, 3'b000} +: 8]     = wd[7:0];
            2'b01:   r[{lo[1], 4'b0000} +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err = illegal_f3(req_we, req_funct3) ||
                     misaligned(req_funct3[1:0], req_addr[1:0]);
`else
    assign req_err = illegal_f3(req_we, req_funct3);
`endif

    assign accept = (state_q == IDLE) && req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)                  state_d = RESP;
                    else if (!req_we)             state_d = READ;
                    else if (req_funct3 == 3'b010) state_d = WRITE;
                    else                          state_d = READ;
                end
            end
            READ:    state_d = we_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch on acceptance; DM word captured at the end of READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            buf_q   <= 32'h0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr[ADDR_W+1:0];
                wdata_q <= req_wdata;
                err_q   <= req_err;
            end
            if (state_q == READ) begin
                buf_q <= dm_rd;
            end
        end
    end

    // dm_addr keeps the last latched word address in every state.
    assign dm_addr = addr_q[ADDR_W+1:2];

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'h0;
        dm_we     = 1'b0;
        dm_wd     = 32'h0;
        case (state_q)
            IDLE:  req_ready = 1'b1;
            WRITE: begin
                dm_we = 1'b1;
                dm_wd = store_merge(buf_q, wdata_q, f3_q[1:0], addr_q[1:0]);
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (!err_q && !we_q) begin
                    rsp_rdata = load_extract(buf_q, f3_q, addr_q[1:0]);
                end
            end
            default: ;
        endcase
    end

endmodule
